// File: rtl/sys_arr_pkg.sv
// sys_arr_pkg: widths and lane types shared by the systolic array PE, row and collector blocks.
package sys_arr_pkg;
   localparam int PE_DATA_WIDTH = 8;
   localparam int PE_SUM_WIDTH = 16;

   typedef logic [PE_SUM_WIDTH-1:0] sum_t;

   typedef struct packed {
      logic act;
      sum_t sum;
   } lane_t;

   function automatic int vec_width(input int w);
      return PE_SUM_WIDTH * w;
   endfunction
endpackage

// File: rtl/sys_arr_out_fifo.sv
// sys_arr_out_fifo: synchronous FIFO with registered head, count, full and empty.
module sys_arr_out_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push,
   input  logic [WIDTH-1:0]        wdata,
   input  logic                    pop,
   output logic [WIDTH-1:0]        head,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    full,
   output logic                    empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic             full_q, full_d, empty_q, empty_d, wr_en, rd_en;

   always_comb begin
      rd_en   = pop && !empty_q;
      wr_en   = push && (!full_q || rd_en);
      mem_d   = mem_q;
      if (wr_en) mem_d[wr_q] = wdata;
      wr_d    = wr_en ? wr_q + 1'b1 : wr_q;
      rd_d    = rd_en ? rd_q + 1'b1 : rd_q;
      count_d = count_q + CW'(wr_en) - CW'(rd_en);
      full_d  = count_d == CW'(DEPTH);
      empty_d = count_d == '0;
      // the incoming word becomes the head when nothing else remains ahead of it
      head_d  = (wr_en && count_q == CW'(rd_en)) ? wdata : rd_en ? mem_q[rd_d] : head_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q   <= '{default: '0};
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         head_q  <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         mem_q   <= mem_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
         head_q  <= head_d;
         full_q  <= full_d;
         empty_q <= empty_d;
      end
   end

   assign head  = head_q;
   assign count = count_q;
   assign full  = full_q;
   assign empty = empty_q;
endmodule

// File: rtl/sys_arr_collect.sv
// sys_arr_collect: deskews the last array row into aligned result vectors and
// buffers them for a valid/ready consumer.
module sys_arr_collect
   import sys_arr_pkg::*;
#(
   parameter int ROW_WIDTH  = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [PE_SUM_WIDTH*ROW_WIDTH-1:0]  maccin,
   input  logic [ROW_WIDTH-1:0]               activein,
   input  logic                               out_ready,
   output logic                               out_valid,
   output logic [PE_SUM_WIDTH*ROW_WIDTH-1:0]  out_data,
   output logic [$clog2(FIFO_DEPTH):0]        fifo_count,
   output logic [15:0]                        vec_count,
   output logic                               overflow,
   output logic                               skew_err
);
   localparam int W  = ROW_WIDTH;
   localparam int VW = vec_width(ROW_WIDTH);

   logic [W-1:0]  al_act;
   logic [VW-1:0] al_data;
   logic          full, empty, pop, push, accept;
   logic [15:0]   vec_count_q, vec_count_d;
   logic          overflow_q, overflow_d, skew_err_q, skew_err_d;

   // one capture stage on every column plus W-1-c deskew stages for column c
   for (genvar c = 0; c < W; c++) begin : g_col
      localparam int N = W - c;
      lane_t sr_q [N];
      lane_t sr_d [N];
      always_comb begin
         sr_d[0] = {activein[c], maccin[c*PE_SUM_WIDTH +: PE_SUM_WIDTH]};
         for (int j = 1; j < N; j++) sr_d[j] = sr_q[j-1];
      end
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) sr_q <= '{default: '0};
         else sr_q <= sr_d;
      end
      assign al_act[c] = sr_q[N-1].act;
      assign al_data[c*PE_SUM_WIDTH +: PE_SUM_WIDTH] = sr_q[N-1].sum;
   end

   always_comb begin
      pop         = !empty && out_ready;
      push        = al_act[0];
      accept      = push && (!full || pop);
      vec_count_d = vec_count_q + 16'(accept);
      overflow_d  = overflow_q || (push && full && !pop);
      skew_err_d  = skew_err_q || (al_act != {W{push}});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_count_q <= '0;
         overflow_q  <= 1'b0;
         skew_err_q  <= 1'b0;
      end else begin
         vec_count_q <= vec_count_d;
         overflow_q  <= overflow_d;
         skew_err_q  <= skew_err_d;
      end
   end

   sys_arr_out_fifo #(
      .WIDTH(VW),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk  (clk),
      .rst_n(rst_n),
      .push (push),
      .wdata(al_data),
      .pop  (pop),
      .head (out_data),
      .count(fifo_count),
      .full (full),
      .empty(empty)
   );

   assign out_valid = !empty;
   assign vec_count = vec_count_q;
   assign overflow  = overflow_q;
   assign skew_err  = skew_err_q;
endmodule

// File: tb/tb_sys_arr_collect.sv
// tb_sys_arr_collect: scoreboard bench for a 2-wide and a 4-wide collector.
module tb_sys_arr_collect;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] m2, d2;
   logic [1:0]  a2;
   logic        rdy2, v2, of2, se2;
   logic [2:0]  fc2;
   logic [15:0] vc2;
   logic [63:0] m4, d4;
   logic [3:0]  a4;
   logic        rdy4, v4, of4, se4;
   logic [2:0]  fc4;
   logic [15:0] vc4;

   bit [15:0] sd2 [2][1024];
   bit        sa2 [2][1024];
   bit [15:0] sd4 [4][1024];
   bit        sa4 [4][1024];
   logic [31:0] q2 [$];
   logic [63:0] q4 [$];
   int total = 0, bad = 0, cyc = 0, t;

   sys_arr_collect #(.ROW_WIDTH(2), .FIFO_DEPTH(4)) u2 (
      .clk(clk), .rst_n(rst_n), .maccin(m2), .activein(a2), .out_ready(rdy2),
      .out_valid(v2), .out_data(d2), .fifo_count(fc2), .vec_count(vc2),
      .overflow(of2), .skew_err(se2));

   sys_arr_collect #(.ROW_WIDTH(4), .FIFO_DEPTH(4)) u4 (
      .clk(clk), .rst_n(rst_n), .maccin(m4), .activein(a4), .out_ready(rdy4),
      .out_valid(v4), .out_data(d4), .fifo_count(fc4), .vec_count(vc4),
      .overflow(of4), .skew_err(se4));

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   task automatic issue2(input int ts, input logic [31:0] v, input logic [1:0] act);
      for (int c = 0; c < 2; c++) begin
         sd2[c][ts+c] = v[c*16 +: 16];
         sa2[c][ts+c] = act[c];
      end
   endtask

   task automatic issue4(input int ts, input logic [63:0] v, input logic [3:0] act);
      for (int c = 0; c < 4; c++) begin
         sd4[c][ts+c] = v[c*16 +: 16];
         sa4[c][ts+c] = act[c];
      end
   endtask

   function automatic logic [63:0] sv(input int n, input int base);
      logic [63:0] r;
      for (int i = 0; i < 4; i++) r[i*16 +: 16] = 16'(base + n*16 + i);
      return r;
   endfunction

   task automatic run(input int n);
      repeat (n) begin
         for (int c = 0; c < 2; c++) begin
            m2[c*16 +: 16] = sd2[c][cyc];
            a2[c] = sa2[c][cyc];
         end
         for (int c = 0; c < 4; c++) begin
            m4[c*16 +: 16] = sd4[c][cyc];
            a4[c] = sa4[c][cyc];
         end
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (rst_n && v2 && rdy2) begin
         if (q2.size() == 0) begin
            total++;
            bad++;
            $display("FAIL u2_unexpected: got %h required no vector", d2);
         end else chk("u2_pop", 64'(d2), 64'(q2.pop_front()));
      end
   end

   initial forever begin
      @(negedge clk);
      if (rst_n && v4 && rdy4) begin
         if (q4.size() == 0) begin
            total++;
            bad++;
            $display("FAIL u4_unexpected: got %h required no vector", d4);
         end else chk("u4_pop", d4, q4.pop_front());
      end else if (rst_n && v4 && q4.size() > 0) chk("u4_stall_head", d4, q4[0]);
   end

   initial begin
      rdy2 = 1'b1;
      rdy4 = 1'b1;
      m2 = '0; a2 = '0; m4 = '0; a4 = '0;
      run(2);
      chk("rst_u2_flags", {v2, fc2, vc2, of2, se2}, 0);
      chk("rst_u2_data", 64'(d2), 0);
      chk("rst_u4_flags", {v4, fc4, vc4, of4, se4}, 0);
      chk("rst_u4_data", d4, 0);
      rst_n = 1'b1;
      run(2);

      issue2(cyc, 32'hFFFE_0005, 2'b11);
      q2.push_back(32'hFFFE_0005);
      run(2);
      chk("w2_not_early", 64'(v2), 0);
      run(1);
      chk("w2_valid", 64'(v2), 1);
      chk("w2_data", 64'(d2), 64'hFFFE_0005);
      run(1);
      chk("w2_fifo_count", 64'(fc2), 0);
      chk("w2_vec_count", 64'(vc2), 1);

      t = cyc;
      for (int n = 0; n < 8; n++) begin
         issue4(t + n, sv(n, 0), 4'hF);
         q4.push_back(sv(n, 0));
      end
      run(4);
      chk("w4_not_early", 64'(v4), 0);
      run(1);
      chk("w4_first_valid", 64'(v4), 1);
      chk("w4_first_data", d4, sv(0, 0));
      for (int n = 1; n < 8; n++) begin
         run(1);
         chk("w4_b2b_valid", 64'(v4), 1);
         chk("w4_b2b_data", d4, sv(n, 0));
      end
      run(3);
      chk("w4_stream_fc", 64'(fc4), 0);
      chk("w4_stream_vc", 64'(vc4), 8);
      chk("w4_stream_flags", {of4, se4}, 0);

      rdy4 = 1'b0;
      t = cyc;
      for (int n = 0; n < 5; n++) begin
         issue4(t + n, sv(n, 16'h100), 4'hF);
         q4.push_back(sv(n, 16'h100));
      end
      run(8);
      chk("full_fc", 64'(fc4), 4);
      rdy4 = 1'b1;
      run(1);
      rdy4 = 1'b0;
      chk("pushpop_fc", 64'(fc4), 4);
      chk("pushpop_ovf", 64'(of4), 0);
      chk("pushpop_vc", 64'(vc4), 13);
      run(2);
      rdy4 = 1'b1;
      run(6);
      chk("pushpop_drain", 64'(fc4), 0);

      rdy4 = 1'b0;
      t = cyc;
      for (int n = 0; n < 5; n++) begin
         issue4(t + n, sv(n, 16'h200), 4'hF);
         if (n < 4) q4.push_back(sv(n, 16'h200));
      end
      run(10);
      chk("ovf_fc", 64'(fc4), 4);
      chk("ovf_flag", 64'(of4), 1);
      chk("ovf_vc", 64'(vc4), 17);
      rdy4 = 1'b1;
      run(6);
      chk("ovf_drain_fc", 64'(fc4), 0);
      chk("ovf_drain_valid", 64'(v4), 0);

      chk("skew_before", 64'(se4), 0);
      t = cyc;
      issue4(t, sv(0, 16'h300), 4'b1101);
      q4.push_back(sv(0, 16'h300));
      run(5);
      chk("skew_set", 64'(se4), 1);
      chk("skew_pushed", 64'(v4), 1);
      chk("skew_vc", 64'(vc4), 18);
      run(3);
      chk("skew_sticky", 64'(se4), 1);

      rdy4 = 1'b0;
      t = cyc;
      for (int n = 0; n < 4; n++) issue4(t + n, sv(n, 16'h400), 4'hF);
      run(7);
      chk("pre_rst_fc", 64'(fc4), 3);
      rst_n = 1'b0;
      #1;
      chk("arst_flags", {v4, fc4, vc4, of4, se4}, 0);
      chk("arst_data", d4, 0);
      run(2);
      rst_n = 1'b1;
      rdy4 = 1'b1;
      run(12);
      chk("post_rst_flags", {v4, fc4, vc4, of4, se4}, 0);

      chk("q2_drained", 64'(q2.size()), 0);
      chk("q4_drained", 64'(q4.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
